// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - decode stage control word layout, field constants, halt codes and FSM states
package idu_pkg;

  localparam int CTRL_W         = 20;
  localparam int EXT_OP_LSB     = 0;
  localparam int ALU_BSRC_LSB   = 3;
  localparam int ALU_ASRC_BIT   = 5;
  localparam int ALU_CTR_LSB    = 6;
  localparam int REG_WR_BIT     = 10;
  localparam int BRANCH_LSB     = 11;
  localparam int MEM_OP_LSB     = 14;
  localparam int MEM_TO_REG_BIT = 17;
  localparam int MEM_WR_BIT     = 18;
  localparam int CSR_CTR_BIT    = 19;

  // Packed MSB-first so the bit positions match the offsets above.
  typedef struct packed {
    logic       csr_ctr;
    logic       mem_wr;
    logic       mem_to_reg;
    logic [2:0] mem_op;
    logic [2:0] branch;
    logic       reg_wr;
    logic [3:0] alu_ctr;
    logic       alu_asrc;
    logic [1:0] alu_bsrc;
    logic [2:0] ext_op;
  } ctrl_t;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_U = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_SUB   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_COPYB = 4'd15;

  // Unsigned branch variants share BLT/BGE and are told apart by alu_ctr.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JAL  = 3'd1;
  localparam logic [2:0] BR_JALR = 3'd2;
  localparam logic [2:0] BR_BEQ  = 3'd4;
  localparam logic [2:0] BR_BNE  = 3'd5;
  localparam logic [2:0] BR_BLT  = 3'd6;
  localparam logic [2:0] BR_BGE  = 3'd7;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_EBREAK  = 2'd2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

endpackage

// File: rtl/idu_imm_gen.sv
// rtl/idu_imm_gen.sv - combinational I/U/S/B/J immediate generator, sign-extended to XLEN
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      ext_op,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (ext_op)
      EXT_I:   imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      EXT_U:   imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      EXT_S:   imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      EXT_B:   imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      EXT_J:   imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - RV32I/E decode stage with GPR file and one output register
// Optional macro IDU_WB_BYPASS_EN forwards a same-cycle write-back into the register reads.
module idu_stage
  import idu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_pc,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              halt,
  output logic [1:0]        halt_code
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [5:0] NREG_L = 6'(NREG);

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_gpr [NREG];
  logic            r_out_valid;
  ctrl_t           r_out_ctrl;
  logic [XLEN-1:0] r_out_imm, r_out_rs1, r_out_rs2, r_out_pc;
  logic [4:0]      r_out_rd;
  logic [1:0]      r_halt_code;

  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_legal, w_ebreak, w_use_rs1, w_use_rs2, w_use_rd;
  logic            w_reg_bad, w_illegal, w_halt_req, w_accept, w_fire, w_wb_ok;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_rs1    = inst[19:15];
  assign w_rs2    = inst[24:20];
  assign w_rd     = inst[11:7];

  always_comb begin
    w_ctrl    = '0;
    w_legal   = 1'b1;
    w_ebreak  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (w_opcode)
      OPC_LOAD: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_I; w_ctrl.alu_bsrc = BSRC_IMM; w_ctrl.reg_wr = 1'b1;
        w_ctrl.mem_op = w_funct3; w_ctrl.mem_to_reg = 1'b1;
        w_legal = w_funct3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
      end
      OPC_OPIMM: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_I; w_ctrl.alu_bsrc = BSRC_IMM; w_ctrl.reg_wr = 1'b1;
        w_ctrl.alu_ctr = {inst[30] & (w_funct3 == 3'd5), w_funct3};
      end
      OPC_AUIPC: begin
        w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_U; w_ctrl.alu_asrc = 1'b1; w_ctrl.alu_bsrc = BSRC_IMM;
        w_ctrl.reg_wr = 1'b1;
      end
      OPC_STORE: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_ctrl.ext_op = EXT_S; w_ctrl.alu_bsrc = BSRC_IMM;
        w_ctrl.mem_op = w_funct3; w_ctrl.mem_wr = 1'b1;
        w_legal = (w_funct3 <= MEM_W);
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
        w_ctrl.reg_wr  = 1'b1;
        w_ctrl.alu_ctr = {inst[30] & (w_funct3 == 3'd0 || w_funct3 == 3'd5), w_funct3};
      end
      OPC_LUI: begin
        w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_U; w_ctrl.alu_bsrc = BSRC_IMM; w_ctrl.alu_ctr = ALU_COPYB;
        w_ctrl.reg_wr = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 {0,1,4,5,6,7} folds onto BEQ/BNE/BLT/BGE; bit 1 selects unsigned compare
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_ctrl.ext_op  = EXT_B;
        w_ctrl.branch  = {1'b1, w_funct3[2], w_funct3[0]};
        w_ctrl.alu_ctr = w_funct3[2] ? (w_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        w_legal = (w_funct3 != 3'd2) && (w_funct3 != 3'd3);
      end
      OPC_JAL: begin
        w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_J; w_ctrl.alu_asrc = 1'b1; w_ctrl.alu_bsrc = BSRC_FOUR;
        w_ctrl.reg_wr = 1'b1; w_ctrl.branch = BR_JAL;
      end
      OPC_JALR: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        w_ctrl.ext_op = EXT_I; w_ctrl.alu_asrc = 1'b1; w_ctrl.alu_bsrc = BSRC_FOUR;
        w_ctrl.reg_wr = 1'b1; w_ctrl.branch = BR_JALR;
        w_legal = (w_funct3 == 3'd0);
      end
      OPC_SYSTEM: begin
        if (w_funct3 == 3'd1) begin
          w_use_rs1 = 1'b1; w_use_rd = 1'b1;
          w_ctrl.ext_op = EXT_I; w_ctrl.reg_wr = 1'b1; w_ctrl.csr_ctr = 1'b1;
        end else if (inst == INST_ECALL) begin
          w_ctrl.csr_ctr = 1'b1;
        end else if (inst == INST_EBREAK) begin
          w_ebreak = 1'b1;
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_reg_bad  = (w_use_rs1 && ({1'b0, w_rs1} >= NREG_L)) ||
                      (w_use_rs2 && ({1'b0, w_rs2} >= NREG_L)) ||
                      (w_use_rd  && ({1'b0, w_rd}  >= NREG_L));
  assign w_illegal  = !w_legal || w_reg_bad;
  assign w_halt_req = w_illegal || w_ebreak;
  assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_fire     = w_accept && !w_halt_req;
  assign w_wb_ok    = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG_L);

  idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst   (inst),
    .ext_op (w_ctrl.ext_op),
    .imm    (w_imm)
  );

  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 5'd0 && {1'b0, w_rs1} < NREG_L) w_rs1_data = r_gpr[w_rs1[AW-1:0]];
    if (w_rs2 != 5'd0 && {1'b0, w_rs2} < NREG_L) w_rs2_data = r_gpr[w_rs2[AW-1:0]];
`ifdef IDU_WB_BYPASS_EN
    if (w_wb_ok && wb_addr == w_rs1) w_rs1_data = wb_data;
    if (w_wb_ok && wb_addr == w_rs2) w_rs2_data = wb_data;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && w_accept && w_halt_req) w_state_nxt = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_imm   <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rd    <= '0;
      r_out_pc    <= '0;
      r_halt_code <= HALT_NONE;
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
    end else begin
      if (w_fire) begin
        r_out_ctrl <= w_ctrl;
        r_out_imm  <= w_imm;
        r_out_rs1  <= w_rs1_data;
        r_out_rs2  <= w_rs2_data;
        r_out_rd   <= w_use_rd ? w_rd : 5'd0;
        r_out_pc   <= pc;
      end
      if (w_fire)         r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
      // Accept is only possible in RUN, so this captures the first cause only.
      if (w_accept && w_halt_req) r_halt_code <= w_illegal ? HALT_ILLEGAL : HALT_EBREAK;
      if (w_wb_ok) r_gpr[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_ctrl     = r_out_ctrl;
  assign out_imm      = r_out_imm;
  assign out_rs1_data = r_out_rs1;
  assign out_rs2_data = r_out_rs2;
  assign out_rd       = r_out_rd;
  assign out_pc       = r_out_pc;
  assign halt         = (r_state == ST_HALT);
  assign halt_code    = r_halt_code;

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - directed self-checking bench for idu_stage (NREG=32 and NREG=16 instances)
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, wb_en;
  logic [31:0] inst, pc, wb_data;
  logic [4:0]  wb_addr;

  logic        in_ready, out_valid, halt;
  logic [19:0] out_ctrl;
  logic [31:0] out_imm, out_rs1_data, out_rs2_data, out_pc;
  logic [4:0]  out_rd;
  logic [1:0]  halt_code;

  logic        e_in_ready, e_out_valid, e_halt;
  logic [19:0] e_out_ctrl;
  logic [31:0] e_out_imm, e_out_rs1_data, e_out_rs2_data, e_out_pc;
  logic [4:0]  e_out_rd;
  logic [1:0]  e_halt_code;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] inst;
    logic [19:0] ctrl;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        chk_imm;
    logic        chk_rs;
  } vec_t;
  vec_t v [11];

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  always #5 clk = ~clk;

  idu_stage #(.NREG(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_pc(out_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halt(halt), .halt_code(halt_code)
  );

  idu_stage #(.NREG(16), .XLEN(32)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .inst(inst), .pc(pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_ctrl(e_out_ctrl), .out_imm(e_out_imm),
    .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data), .out_rd(e_out_rd), .out_pc(e_out_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halt(e_halt), .halt_code(e_halt_code)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    inst = 32'h0; pc = 32'h0; wb_addr = 5'd0; wb_data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    // reset must win over a simultaneous accept and write-back
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; inst = ADDI_X1_5; pc = 32'h44;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_total++; if (halt !== 1'b0) $display("FAIL rst_halt: got %0b want 0", halt); else n_pass++;
    n_total++; if (halt_code !== 2'd0) $display("FAIL rst_halt_code: got %0d want 0", halt_code); else n_pass++;
    n_total++; if (out_ctrl !== 20'h0) $display("FAIL rst_ctrl: got %h want 0", out_ctrl); else n_pass++;
    n_total++; if (out_imm !== 32'h0) $display("FAIL rst_imm: got %h want 0", out_imm); else n_pass++;
    n_total++; if (out_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", out_pc); else n_pass++;
  endtask

  task automatic test_addi();
    do_wb(5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    in_valid = 1'b1; inst = ADDI_X1_5; pc = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_imm !== 32'd5) $display("FAIL addi_imm: got %h want 5", out_imm); else n_pass++;
    n_total++; if (out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", out_rd); else n_pass++;
    n_total++; if (out_rs1_data !== 32'h0) $display("FAIL addi_rs1_x0: got %h want 0", out_rs1_data); else n_pass++;
    n_total++; if (out_ctrl !== 20'h00408) $display("FAIL addi_ctrl: got %h want 00408", out_ctrl); else n_pass++;
    n_total++; if (out_pc !== 32'h8000_0000) $display("FAIL addi_pc: got %h want 80000000", out_pc); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL addi_drain: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = ADDI_X1_5; pc = 32'h10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b want 1", c, out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %0b want 0", c, in_ready); else n_pass++;
      n_total++; if (out_imm !== 32'd5 || out_rd !== 5'd1 || out_ctrl !== 20'h00408 || out_pc !== 32'h10)
        $display("FAIL stall_hold[%0d]: got imm=%h rd=%0d ctrl=%h pc=%h want 5/1/00408/10", c, out_imm, out_rd, out_ctrl, out_pc);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL stall_release_once: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    v[0]  = '{32'h1234_5137, 20'h007C9, 32'h1234_5000, 5'd2, 32'h0,   32'h0,   1'b1, 1'b0}; // lui x2
    v[1]  = '{32'hFE20_8CE3, 20'h02203, 32'hFFFF_FFF8, 5'd0, 32'h100, 32'hABC, 1'b1, 1'b1}; // beq x1,x2,-8
    v[2]  = '{32'h0020_A423, 20'h4800A, 32'h0000_0008, 5'd0, 32'h100, 32'hABC, 1'b1, 1'b1}; // sw x2,8(x1)
    v[3]  = '{32'h0010_00EF, 20'h00C34, 32'h0000_0800, 5'd1, 32'h0,   32'h0,   1'b1, 1'b0}; // jal x1,0x800
    v[4]  = '{32'hFFC1_2183, 20'h28408, 32'hFFFF_FFFC, 5'd3, 32'hABC, 32'h0,   1'b1, 1'b1}; // lw x3,-4(x2)
    v[5]  = '{32'h4020_8233, 20'h00600, 32'h0,         5'd4, 32'h100, 32'hABC, 1'b0, 1'b1}; // sub x4,x1,x2
    v[6]  = '{32'h0020_E863, 20'h030C3, 32'h0000_0010, 5'd0, 32'h100, 32'hABC, 1'b1, 1'b1}; // bltu x1,x2,16
    v[7]  = '{32'h0000_1297, 20'h00429, 32'h0000_1000, 5'd5, 32'h0,   32'h0,   1'b1, 1'b0}; // auipc x5,1
    v[8]  = '{32'h4030_D313, 20'h00748, 32'h0000_0403, 5'd6, 32'h100, 32'h0,   1'b1, 1'b1}; // srai x6,x1,3
    v[9]  = '{32'h3050_93F3, 20'h80400, 32'h0000_0305, 5'd7, 32'h100, 32'h0,   1'b1, 1'b1}; // csrrw x7,0x305,x1
    v[10] = '{32'h0000_0073, 20'h80000, 32'h0,         5'd0, 32'h0,   32'h0,   1'b1, 1'b1}; // ecall
    do_wb(5'd1, 32'h100);
    do_wb(5'd2, 32'hABC);
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %0b want 1", i-1, out_valid); else n_pass++;
        n_total++; if (out_ctrl !== v[i-1].ctrl) $display("FAIL b2b_ctrl[%0d]: got %h want %h", i-1, out_ctrl, v[i-1].ctrl); else n_pass++;
        n_total++; if (out_rd !== v[i-1].rd) $display("FAIL b2b_rd[%0d]: got %0d want %0d", i-1, out_rd, v[i-1].rd); else n_pass++;
        n_total++; if (out_pc !== 32'h100 + 32'(4*(i-1))) $display("FAIL b2b_pc[%0d]: got %h want %h", i-1, out_pc, 32'h100 + 32'(4*(i-1))); else n_pass++;
        if (v[i-1].chk_imm) begin
          n_total++; if (out_imm !== v[i-1].imm) $display("FAIL b2b_imm[%0d]: got %h want %h", i-1, out_imm, v[i-1].imm); else n_pass++;
        end
        if (v[i-1].chk_rs) begin
          n_total++; if (out_rs1_data !== v[i-1].rs1 || out_rs2_data !== v[i-1].rs2)
            $display("FAIL b2b_rs[%0d]: got %h/%h want %h/%h", i-1, out_rs1_data, out_rs2_data, v[i-1].rs1, v[i-1].rs2);
          else n_pass++;
        end
      end
      if (i < 11) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, in_ready); else n_pass++;
        in_valid = 1'b1; inst = v[i].inst; pc = 32'h100 + 32'(4*i);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs1;
`ifdef IDU_WB_BYPASS_EN
    exp_rs1 = 32'hDEAD_BEEF;
`else
    exp_rs1 = 32'h0;
`endif
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; inst = 32'h0002_8333; pc = 32'h200;
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    n_total++; if (out_rs1_data !== exp_rs1) $display("FAIL bypass_rs1: got %h want %h", out_rs1_data, exp_rs1); else n_pass++;
    n_total++; if (out_ctrl !== 20'h00400 || out_rd !== 5'd6) $display("FAIL bypass_ctrl_rd: got %h/%0d want 00400/6", out_ctrl, out_rd); else n_pass++;
    @(negedge clk);
    in_valid = 1'b1; inst = 32'h0002_8333;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0;
    n_total++; if (out_rs1_data !== 32'hDEAD_BEEF) $display("FAIL gpr_updated: got %h want deadbeef", out_rs1_data); else n_pass++;
    n_total++; if (out_rs2_data !== 32'h0) $display("FAIL x0_wb_bypass: got %h want 0", out_rs2_data); else n_pass++;
  endtask

  task automatic test_ebreak();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; inst = EBREAK;
    @(negedge clk);
    inst = ADDI_X1_5;
    n_total++; if (halt !== 1'b1 || halt_code !== 2'd2) $display("FAIL ebreak_halt: got %0b/%0d want 1/2", halt, halt_code); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ebreak_no_bundle: got %0b want 0", out_valid); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || halt !== 1'b1)
        $display("FAIL ebreak_stuck[%0d]: got ready=%0b valid=%0b halt=%0b want 0/0/1", c, in_ready, out_valid, halt);
      else n_pass++;
    end
    do_reset();
    n_total++; if (halt !== 1'b0 || halt_code !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL halt_rst: got halt=%0b code=%0d ready=%0b want 0/0/1", halt, halt_code, in_ready);
    else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; inst = 32'hFFFF_FFFF;
    @(negedge clk);
    inst = EBREAK;
    n_total++; if (halt !== 1'b1 || halt_code !== 2'd1) $display("FAIL illegal_halt: got %0b/%0d want 1/1", halt, halt_code); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL illegal_no_bundle: got %0b want 0", out_valid); else n_pass++;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (halt_code !== 2'd1) $display("FAIL illegal_first_cause: got %0d want 1", halt_code); else n_pass++;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; inst = 32'h0000_B083; // load with funct3=3
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (halt_code !== 2'd1 || out_valid !== 1'b0) $display("FAIL illegal_funct3: got %0d/%0b want 1/0", halt_code, out_valid); else n_pass++;
  endtask

  task automatic test_rv32e();
    do_reset();
    do_wb(5'd20, 32'h0000_0BAD);
    @(negedge clk);
    in_valid = 1'b1; inst = 32'h0002_0093; // addi x1,x4,0
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (e_out_valid !== 1'b1 || e_out_rs1_data !== 32'h0)
      $display("FAIL e_wb_x20_ignored: got valid=%0b x4=%h want 1/0", e_out_valid, e_out_rs1_data);
    else n_pass++;
    do_wb(5'd3, 32'h55);
    @(negedge clk);
    in_valid = 1'b1; inst = 32'h0001_8213; // addi x4,x3,0
    @(negedge clk);
    inst = 32'h0000_0A13; // addi x20,x0,0
    n_total++; if (e_out_rs1_data !== 32'h55 || e_out_rd !== 5'd4) $display("FAIL e_read_x3: got %h/%0d want 55/4", e_out_rs1_data, e_out_rd); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (e_halt !== 1'b1 || e_halt_code !== 2'd1) $display("FAIL e_x20_illegal: got %0b/%0d want 1/1", e_halt, e_halt_code); else n_pass++;
    n_total++; if (e_out_valid !== 1'b0) $display("FAIL e_x20_no_bundle: got %0b want 0", e_out_valid); else n_pass++;
    n_total++; if (halt !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd20)
      $display("FAIL rv32i_x20_legal: got halt=%0b valid=%0b rd=%0d want 0/1/20", halt, out_valid, out_rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall();
    test_back_to_back();
    test_bypass();
    test_ebreak();
    test_illegal();
    test_rv32e();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
